maple_frame_decoder: RTL and testbench



---
 rtl/maple_frame_decoder_if.sv | 31 +++
 rtl/maple_frame_decoder.sv | 194 +++++++++++++++++++
 tb/tb_maple_frame_decoder.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maple_frame_decoder_if.sv
// Maple frame decoder bus: edge strobes from the edge detector in,
// decoded words and frame status out to the frame buffer.
interface maple_frame_decoder_if #(
    parameter int WORD_BITS = 8,
    parameter int CNT_W     = 11
);
    logic                 enable;
    logic                 sdcka_data;
    logic                 sdcka_negedge;
    logic                 sdckb_data;
    logic                 sdckb_negedge;
    logic [WORD_BITS-1:0] word;
    logic                 word_valid;
    logic [CNT_W-1:0]     word_count;
    logic [7:0]           checksum;
    logic                 frame_done;
    logic                 frame_partial;
    logic                 frame_overflow;

    modport master (
        output enable, sdcka_data, sdcka_negedge, sdckb_data, sdckb_negedge,
        input  word, word_valid, word_count, checksum,
               frame_done, frame_partial, frame_overflow
    );

    modport slave (
        input  enable, sdcka_data, sdcka_negedge, sdckb_data, sdckb_negedge,
        output word, word_valid, word_count, checksum,
               frame_done, frame_partial, frame_overflow
    );
endinterface

// File: rtl/maple_frame_decoder.sv
// Maple frame decoder: turns alternating SDCKA/SDCKB falling-edge strobes
// into WORD_BITS-wide words, counting words, keeping an XOR checksum of
// all bytes and flagging partial or overflowed frames.
module maple_frame_decoder #(
    parameter int WORD_BITS = 8,
    parameter int MAX_WORDS = 1028,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    maple_frame_decoder_if.slave bus
);
    localparam int BC_W = $clog2(WORD_BITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PHASE1 = 2'd1,
        PHASE2 = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [BC_W-1:0]      bitCnt_q, bitCnt_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic                 wordValid_q, wordValid_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [7:0]           checksum_q, checksum_d;
    logic                 partial_q, partial_d;
    logic                 overflow_q, overflow_d;

    logic                 frameStart;
    logic                 shiftEn;
    logic                 shiftBit;
    logic                 enterDone;
    logic                 frameDone;

    logic [WORD_BITS-1:0] shiftBase;
    logic [BC_W-1:0]      cntBase;
    logic [CNT_W-1:0]     countBase;
    logic [7:0]           checksumBase;
    logic [WORD_BITS-1:0] newShift;

    function automatic logic [7:0] byteXor(input logic [WORD_BITS-1:0] w);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < WORD_BITS / 8; i++) begin
            acc = acc ^ w[i*8 +: 8];
        end
        return acc;
    endfunction

    // State register; reset may land mid-frame and abandons it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: phases alternate on the matching strobe, enable low wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = bus.sdcka_negedge ? PHASE2 : PHASE1;
                end
            end
            PHASE1: begin
                if (!bus.enable) begin
                    state_d = DONE;
                end else if (bus.sdcka_negedge) begin
                    state_d = PHASE2;
                end
            end
            PHASE2: begin
                if (!bus.enable) begin
                    state_d = DONE;
                end else if (bus.sdckb_negedge) begin
                    state_d = PHASE1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM decodes: which bit (if any) is captured this cycle, frame start/end.
    always_comb begin
        frameStart = 1'b0;
        shiftEn    = 1'b0;
        shiftBit   = 1'b0;
        enterDone  = 1'b0;
        frameDone  = 1'b0;
        case (state_q)
            IDLE: begin
                frameStart = bus.enable;
                shiftEn    = bus.enable & bus.sdcka_negedge;
                shiftBit   = bus.sdckb_data;
            end
            PHASE1: begin
                enterDone = ~bus.enable;
                shiftEn   = bus.enable & bus.sdcka_negedge;
                shiftBit  = bus.sdckb_data;
            end
            PHASE2: begin
                enterDone = ~bus.enable;
                shiftEn   = bus.enable & bus.sdckb_negedge;
                shiftBit  = bus.sdcka_data;
            end
            DONE:    frameDone = 1'b1;
            default: frameDone = 1'b0;
        endcase
    end

    // A new frame starts from a clean slate even if its first bit lands now.
    assign shiftBase    = frameStart ? '0 : shift_q;
    assign cntBase      = frameStart ? '0 : bitCnt_q;
    assign countBase    = frameStart ? '0 : count_q;
    assign checksumBase = frameStart ? '0 : checksum_q;
    assign newShift     = {shiftBase[WORD_BITS-2:0], shiftBit};

    // Datapath next state: shift, word completion, overflow and partial flags.
    always_comb begin
        shift_d     = shift_q;
        bitCnt_d    = bitCnt_q;
        word_d      = word_q;
        wordValid_d = 1'b0;
        count_d     = count_q;
        checksum_d  = checksum_q;
        partial_d   = partial_q;
        overflow_d  = overflow_q;
        if (frameStart) begin
            shift_d    = '0;
            bitCnt_d   = '0;
            count_d    = '0;
            checksum_d = '0;
            partial_d  = 1'b0;
            overflow_d = 1'b0;
        end
        if (shiftEn) begin
            shift_d = newShift;
            if (cntBase == BC_W'(WORD_BITS - 1)) begin
                bitCnt_d = '0;
                if (countBase == CNT_W'(MAX_WORDS)) begin
                    overflow_d = 1'b1;
                end else begin
                    word_d      = newShift;
                    wordValid_d = 1'b1;
                    count_d     = countBase + CNT_W'(1);
                    checksum_d  = checksumBase ^ byteXor(newShift);
                end
            end else begin
                bitCnt_d = cntBase + BC_W'(1);
            end
        end
        if (enterDone) begin
            partial_d = (bitCnt_q != '0);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q     <= '0;
            bitCnt_q    <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
            count_q     <= '0;
            checksum_q  <= '0;
            partial_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            word_q      <= word_d;
            wordValid_q <= wordValid_d;
            count_q     <= count_d;
            checksum_q  <= checksum_d;
            partial_q   <= partial_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.word           = word_q;
    assign bus.word_valid     = wordValid_q;
    assign bus.word_count     = count_q;
    assign bus.checksum       = checksum_q;
    assign bus.frame_done     = frameDone;
    assign bus.frame_partial  = partial_q;
    assign bus.frame_overflow = overflow_q;
endmodule

// File: tb/tb_maple_frame_decoder.sv
// Bench for maple_frame_decoder: three instances (8-bit, 32-bit, 8-bit with
// MAX_WORDS=2) share one stimulus stream; a frame-level model predicts each.
module tb_maple_frame_decoder;
    logic clk = 1'b0;
    logic reset;
    logic enable, aData, aNeg, bData, bNeg;

    always #5 clk = ~clk;

    maple_frame_decoder_if #(.WORD_BITS(8),  .CNT_W(11)) if8();
    maple_frame_decoder_if #(.WORD_BITS(32), .CNT_W(11)) if32();
    maple_frame_decoder_if #(.WORD_BITS(8),  .CNT_W(11)) ifOv();

    assign if8.enable         = enable;
    assign if8.sdcka_data     = aData;
    assign if8.sdcka_negedge  = aNeg;
    assign if8.sdckb_data     = bData;
    assign if8.sdckb_negedge  = bNeg;
    assign if32.enable        = enable;
    assign if32.sdcka_data    = aData;
    assign if32.sdcka_negedge = aNeg;
    assign if32.sdckb_data    = bData;
    assign if32.sdckb_negedge = bNeg;
    assign ifOv.enable        = enable;
    assign ifOv.sdcka_data    = aData;
    assign ifOv.sdcka_negedge = aNeg;
    assign ifOv.sdckb_data    = bData;
    assign ifOv.sdckb_negedge = bNeg;

    maple_frame_decoder #(.WORD_BITS(8),  .MAX_WORDS(1028), .CNT_W(11)) dut8  (.clk(clk), .reset(reset), .bus(if8));
    maple_frame_decoder #(.WORD_BITS(32), .MAX_WORDS(1028), .CNT_W(11)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    maple_frame_decoder #(.WORD_BITS(8),  .MAX_WORDS(2),    .CNT_W(11)) dutOv (.clk(clk), .reset(reset), .bus(ifOv));

    int errors = 0;
    int checks = 0;

    int W[3]    = '{8, 32, 8};
    int MAXW[3] = '{1028, 1028, 2};

    // Reference model state
    logic        frameBits[$];
    logic [31:0] mWord[3];
    int          mCount[3];
    logic [7:0]  mChk[3];
    logic        mPart[3];
    logic        mOvf[3];
    logic [31:0] expWords[3][64];
    int          expN[3];

    // Observations
    logic [31:0] obsWords[3][64];
    int          obsTotal[3] = '{0, 0, 0};
    int          doneTotal[3] = '{0, 0, 0};
    int          frameBase[3];
    int          doneBase[3];

    logic [31:0] aWord[3];
    logic [31:0] aCount[3];
    logic [7:0]  aChk[3];
    logic        aPart[3];
    logic        aOvf[3];

    // Records every word pulse and frame_done pulse seen on each instance.
    always @(negedge clk) begin
        if (if8.word_valid === 1'b1) begin
            obsWords[0][obsTotal[0] % 64] = 32'(if8.word);
            obsTotal[0]++;
        end
        if (if32.word_valid === 1'b1) begin
            obsWords[1][obsTotal[1] % 64] = if32.word;
            obsTotal[1]++;
        end
        if (ifOv.word_valid === 1'b1) begin
            obsWords[2][obsTotal[2] % 64] = 32'(ifOv.word);
            obsTotal[2]++;
        end
        if (if8.frame_done === 1'b1)  doneTotal[0]++;
        if (if32.frame_done === 1'b1) doneTotal[1]++;
        if (ifOv.frame_done === 1'b1) doneTotal[2]++;
    end

    function automatic void snapshot();
        aWord[0] = 32'(if8.word);  aCount[0] = 32'(if8.word_count);
        aChk[0]  = if8.checksum;   aPart[0]  = if8.frame_partial;  aOvf[0] = if8.frame_overflow;
        aWord[1] = if32.word;      aCount[1] = 32'(if32.word_count);
        aChk[1]  = if32.checksum;  aPart[1]  = if32.frame_partial; aOvf[1] = if32.frame_overflow;
        aWord[2] = 32'(ifOv.word); aCount[2] = 32'(ifOv.word_count);
        aChk[2]  = ifOv.checksum;  aPart[2]  = ifOv.frame_partial; aOvf[2] = ifOv.frame_overflow;
    endfunction

    // Frame-level model: split the bit list into words, MSB first.
    function automatic void modelFrame();
        for (int c = 0; c < 3; c++) begin
            int n;
            int nw;
            logic [31:0] w;
            n = frameBits.size();
            nw = n / W[c];
            mCount[c] = 0;
            mChk[c] = 8'h00;
            mOvf[c] = 1'b0;
            expN[c] = 0;
            for (int k = 0; k < nw; k++) begin
                w = '0;
                for (int j = 0; j < W[c]; j++) w = {w[30:0], frameBits[k*W[c] + j]};
                if (k < MAXW[c]) begin
                    mWord[c] = w;
                    mCount[c]++;
                    expWords[c][k] = w;
                    expN[c]++;
                    for (int b = 0; b < W[c] / 8; b++) mChk[c] = mChk[c] ^ 8'(w >> (8 * b));
                end else begin
                    mOvf[c] = 1'b1;
                end
            end
            mPart[c] = (n % W[c]) != 0;
        end
    endfunction

    function automatic void modelReset();
        for (int c = 0; c < 3; c++) begin
            mWord[c] = '0; mCount[c] = 0; mChk[c] = 8'h00; mPart[c] = 1'b0; mOvf[c] = 1'b0;
        end
        frameBits.delete();
    endfunction

    // Idle cycle: random data levels plus an occasional strobe the FSM must ignore.
    task automatic gapCycle(input int idx);
        aData = 1'($urandom);
        bData = 1'($urandom);
        if ($urandom_range(2, 0) == 0) begin
            if (idx % 2 == 0) bNeg = 1'b1;
            else aNeg = 1'b1;
        end
        @(negedge clk);
        aNeg = 1'b0;
        bNeg = 1'b0;
    endtask

    task automatic sendBit(input logic b);
        int idx;
        idx = frameBits.size();
        if (idx % 2 == 0) begin
            aNeg = 1'b1; bData = b; aData = 1'($urandom);
        end else begin
            bNeg = 1'b1; aData = b; bData = 1'($urandom);
        end
        frameBits.push_back(b);
        @(negedge clk);
        aNeg = 1'b0;
        bNeg = 1'b0;
    endtask

    task automatic sendWordBits(input logic [31:0] v, input int nbits, input int gapMax);
        for (int i = nbits - 1; i >= 0; i--) begin
            repeat ($urandom_range(gapMax, 0)) gapCycle(frameBits.size());
            sendBit(v[i]);
        end
    endtask

    task automatic startFrame();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            frameBase[c] = obsTotal[c];
            doneBase[c]  = doneTotal[c];
        end
        frameBits.delete();
        enable = 1'b1;
    endtask

    task automatic endFrame(input bit dropEdge);
        int idx;
        idx = frameBits.size();
        if (dropEdge) begin
            if (idx % 2 == 0) begin aNeg = 1'b1; bData = 1'($urandom); end
            else begin bNeg = 1'b1; aData = 1'($urandom); end
        end
        enable = 1'b0;
        @(negedge clk);
        aNeg = 1'b0;
        bNeg = 1'b0;
        modelFrame();
        for (int i = 0; i < 4 && if8.frame_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (if8.frame_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_done_timeout: got %b expected 1", if8.frame_done);
        end
        snapshot();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b0; aData = 1'b0; aNeg = 1'b0; bData = 1'b0; bNeg = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        snapshot();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({aWord[c], aCount[c], aChk[c], aPart[c], aOvf[c]} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cfg%0d: word=%h count=%0d chk=%h part=%b ovf=%b expected all 0",
                         c, aWord[c], aCount[c], aChk[c], aPart[c], aOvf[c]);
            end
        end
        checks++;
        if ({if8.word_valid, if8.frame_done, if32.word_valid, ifOv.frame_done} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_pulses: got %b expected 0000",
                     {if8.word_valid, if8.frame_done, if32.word_valid, ifOv.frame_done});
        end
        reset = 1'b1;
    endtask

    task automatic test_single_byte();
        startFrame();
        sendWordBits(32'hA5, 8, 2);
        checks++;
        if (if8.word_valid !== 1'b1 || if8.word !== 8'hA5 || if8.word_count !== 11'd1) begin
            errors++;
            $display("[TB] FAIL single_latency: valid=%b word=%h count=%0d expected 1/a5/1",
                     if8.word_valid, if8.word, if8.word_count);
        end
        @(negedge clk);
        checks++;
        if (if8.word_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pulse_width: valid=%b expected 0", if8.word_valid);
        end
        endFrame(1'b0);
        checks++;
        if (aWord[0] !== 32'hA5 || aCount[0] !== 32'd1 || aChk[0] !== 8'hA5 || aPart[0] !== 1'b0 || aOvf[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_byte: word=%h count=%0d chk=%h part=%b ovf=%b expected a5/1/a5/0/0",
                     aWord[0], aCount[0], aChk[0], aPart[0], aOvf[0]);
        end
        @(negedge clk);
        checks++;
        if (if8.frame_done !== 1'b0 || obsTotal[0] - frameBase[0] != 1 || doneTotal[0] - doneBase[0] != 1) begin
            errors++;
            $display("[TB] FAIL single_pulses: done=%b valids=%0d dones=%0d expected 0/1/1",
                     if8.frame_done, obsTotal[0] - frameBase[0], doneTotal[0] - doneBase[0]);
        end
    endtask

    task automatic test_four_bytes();
        logic [7:0] vals[4] = '{8'h01, 8'h02, 8'h04, 8'h80};
        startFrame();
        for (int i = 0; i < 4; i++) sendWordBits(32'(vals[i]), 8, 3);
        endFrame(1'b0);
        checks++;
        if (obsTotal[0] - frameBase[0] != 4) begin
            errors++;
            $display("[TB] FAIL four_valid_count: got %0d expected 4", obsTotal[0] - frameBase[0]);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obsWords[0][(frameBase[0] + i) % 64] !== 32'(vals[i])) begin
                    errors++;
                    $display("[TB] FAIL four_word%0d: got %h expected %h", i,
                             obsWords[0][(frameBase[0] + i) % 64], vals[i]);
                end
            end
        end
        checks++;
        if (aCount[0] !== 32'd4 || aChk[0] !== 8'h87 || aWord[0] !== 32'h80 || aPart[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL four_totals: count=%0d chk=%h word=%h part=%b expected 4/87/80/0",
                     aCount[0], aChk[0], aWord[0], aPart[0]);
        end
    endtask

    task automatic test_back_to_back();
        startFrame();
        sendWordBits(32'hDEADBEEF, 32, 0);
        endFrame(1'b0);
        checks++;
        if (aWord[1] !== 32'hDEADBEEF || aCount[1] !== 32'd1 || aChk[1] !== 8'h22 || aPart[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_32: word=%h count=%0d chk=%h part=%b expected deadbeef/1/22/0",
                     aWord[1], aCount[1], aChk[1], aPart[1]);
        end
        checks++;
        if (aWord[0] !== 32'hEF || aCount[0] !== 32'd4 || aChk[0] !== 8'h22) begin
            errors++;
            $display("[TB] FAIL b2b_8: word=%h count=%0d chk=%h expected ef/4/22", aWord[0], aCount[0], aChk[0]);
        end
    endtask

    task automatic test_partial();
        startFrame();
        sendWordBits(32'h3C, 8, 1);
        sendWordBits(32'($urandom), 5, 1);
        endFrame(1'b0);
        checks++;
        if (aWord[0] !== 32'h3C || aCount[0] !== 32'd1 || aPart[0] !== 1'b1 || obsTotal[0] - frameBase[0] != 1) begin
            errors++;
            $display("[TB] FAIL partial_bits: word=%h count=%0d part=%b valids=%0d expected 3c/1/1/1",
                     aWord[0], aCount[0], aPart[0], obsTotal[0] - frameBase[0]);
        end
        // 15 bits in, so the dropped SDCKB edge would have completed a second byte.
        startFrame();
        sendWordBits(32'h3C, 8, 1);
        sendWordBits(32'($urandom), 7, 1);
        endFrame(1'b1);
        checks++;
        if (aWord[0] !== 32'h3C || aCount[0] !== 32'd1 || aPart[0] !== 1'b1 || obsTotal[0] - frameBase[0] != 1) begin
            errors++;
            $display("[TB] FAIL partial_drop_edge: word=%h count=%0d part=%b valids=%0d expected 3c/1/1/1",
                     aWord[0], aCount[0], aPart[0], obsTotal[0] - frameBase[0]);
        end
    endtask

    task automatic test_overflow();
        startFrame();
        sendWordBits(32'h11, 8, 2);
        sendWordBits(32'h22, 8, 2);
        sendWordBits(32'h33, 8, 2);
        endFrame(1'b0);
        checks++;
        if (aWord[2] !== 32'h22 || aCount[2] !== 32'd2 || aChk[2] !== 8'h33 || aOvf[2] !== 1'b1
            || obsTotal[2] - frameBase[2] != 2) begin
            errors++;
            $display("[TB] FAIL overflow: word=%h count=%0d chk=%h ovf=%b valids=%0d expected 22/2/33/1/2",
                     aWord[2], aCount[2], aChk[2], aOvf[2], obsTotal[2] - frameBase[2]);
        end
        startFrame();
        gapCycle(0);
        checks++;
        if (ifOv.word_count !== 11'd0 || ifOv.checksum !== 8'h00 || ifOv.frame_overflow !== 1'b0
            || ifOv.word !== 8'h22) begin
            errors++;
            $display("[TB] FAIL overflow_clear: count=%0d chk=%h ovf=%b word=%h expected 0/00/0/22",
                     ifOv.word_count, ifOv.checksum, ifOv.frame_overflow, ifOv.word);
        end
        endFrame(1'b0);
    endtask

    task automatic test_reset_midframe();
        startFrame();
        sendWordBits(32'h5, 3, 1);
        reset = 1'b0;
        enable = 1'b0;
        modelReset();
        #1;
        snapshot();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({aWord[c], aCount[c], aChk[c], aPart[c], aOvf[c]} !== '0) begin
                errors++;
                $display("[TB] FAIL midframe_reset cfg%0d: word=%h count=%0d chk=%h expected 0",
                         c, aWord[c], aCount[c], aChk[c]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        startFrame();
        sendWordBits(32'h5A, 8, 2);
        endFrame(1'b0);
        checks++;
        if (aWord[0] !== 32'h5A || aCount[0] !== 32'd1 || aChk[0] !== 8'h5A || aPart[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset: word=%h count=%0d chk=%h part=%b expected 5a/1/5a/0",
                     aWord[0], aCount[0], aChk[0], aPart[0]);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 25; f++) begin
            int nbits;
            int gapMax;
            nbits = $urandom_range(200, 0);
            gapMax = $urandom_range(3, 0);
            startFrame();
            for (int i = 0; i < nbits; i++) begin
                repeat ($urandom_range(gapMax, 0)) gapCycle(frameBits.size());
                sendBit(1'($urandom));
            end
            if (frameBits.size() == 0) gapCycle(0);
            endFrame(1'($urandom));
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (aWord[c] !== mWord[c] || aCount[c] !== 32'(mCount[c]) || aChk[c] !== mChk[c]
                    || aPart[c] !== mPart[c] || aOvf[c] !== mOvf[c]) begin
                    errors++;
                    $display("[TB] FAIL random f%0d cfg%0d: word=%h/%h count=%0d/%0d chk=%h/%h part=%b/%b ovf=%b/%b (got/expected)",
                             f, c, aWord[c], mWord[c], aCount[c], mCount[c], aChk[c], mChk[c],
                             aPart[c], mPart[c], aOvf[c], mOvf[c]);
                end
                checks++;
                if (obsTotal[c] - frameBase[c] != expN[c]) begin
                    errors++;
                    $display("[TB] FAIL random_valids f%0d cfg%0d: got %0d expected %0d",
                             f, c, obsTotal[c] - frameBase[c], expN[c]);
                end else begin
                    for (int k = 0; k < expN[c]; k++) begin
                        checks++;
                        if (obsWords[c][(frameBase[c] + k) % 64] !== expWords[c][k]) begin
                            errors++;
                            $display("[TB] FAIL random_word f%0d cfg%0d #%0d: got %h expected %h",
                                     f, c, k, obsWords[c][(frameBase[c] + k) % 64], expWords[c][k]);
                        end
                    end
                end
            end
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (doneTotal[c] - doneBase[c] != 1) begin
                    errors++;
                    $display("[TB] FAIL random_done f%0d cfg%0d: got %0d pulses expected 1",
                             f, c, doneTotal[c] - doneBase[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_four_bytes();
        test_back_to_back();
        test_partial();
        test_overflow();
        test_reset_midframe();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
